sa_in_skew: RTL and testbench

SA_IN_SKEW -- requirements
Module: sa_in_skew

---
 rtl/sa_in_skew_if.sv | 21 ++
 rtl/sa_in_skew.sv | 138 +++++++++++++
 tb/tb_sa_in_skew.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_in_skew_if.sv
// Upstream row-vector stream into the systolic input skew block.
//   in_valid  : a beat is present (master -> slave)
//   in_ready  : the skew block can take a beat this cycle (slave -> master)
//   in_last   : final beat of a matrix, qualified by in_valid
//   in_data   : LANES data bytes, lane i = bits [DW*i +: DW]
//   in_weight : LANES weight bytes, same packing as in_data
interface sa_in_skew_if #(
   parameter int unsigned LANES = 16,
   parameter int unsigned DW    = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_last;
   logic [LANES*DW-1:0]   in_data;
   logic [LANES*DW-1:0]   in_weight;

   modport master (output in_valid, output in_last, output in_data, output in_weight,
                   input  in_ready);
   modport slave  (input  in_valid, input  in_last, input  in_data, input  in_weight,
                   output in_ready);
endinterface

// File: rtl/sa_in_skew.sv
// Input skew stage for a LANES-wide systolic array. Lane i of both data and
// weight is delayed by i advances, so element rows enter the array as a
// diagonal wavefront. After the last beat of a matrix the chains are pushed
// with LANES-1 zero vectors to drain them, then done pulses.
//   clk, rst_n    : clock, asynchronous active-low reset
//   clr           : synchronous soft clear (back to IDLE, chains zeroed)
//   in_if         : upstream stream (slave side)
//   SA_fire_out   : skewed vector valid this cycle
//   SA_data_out   : skewed data lanes
//   SA_weight_out : skewed weight lanes
//   busy          : in FEED or FLUSH
//   done          : one-cycle pulse with the final drained vector
module sa_in_skew #(
   parameter int unsigned LANES = 16,
   parameter int unsigned DW    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   sa_in_skew_if.slave         in_if,
   output logic                SA_fire_out,
   output logic [LANES*DW-1:0] SA_data_out,
   output logic [LANES*DW-1:0] SA_weight_out,
   output logic                busy,
   output logic                done
);

   localparam int unsigned CW         = 4;
   localparam int unsigned FLUSH_LAST = LANES - 2;

   typedef enum logic [1:0] {IDLE, FEED, FLUSH} state_t;

   state_t         state;
   logic [CW-1:0]  flush_cnt;
   logic           in_ready_q;
   logic           accept_c;
   logic           flush_c;
   logic           adv_c;

   assign in_if.in_ready = in_ready_q;

   // in_ready_q is only ever high outside FLUSH, so acceptance and flush
   // advances never coincide.
   assign accept_c = in_if.in_valid & in_ready_q;
   assign flush_c  = (state == FLUSH);
   assign adv_c    = accept_c | flush_c;

   // Control FSM with registered handshake/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         flush_cnt   <= '0;
         in_ready_q  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         SA_fire_out <= 1'b0;
      end else if (clr) begin
         state       <= IDLE;
         flush_cnt   <= '0;
         in_ready_q  <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         SA_fire_out <= 1'b0;
      end else begin
         SA_fire_out <= adv_c;
         done        <= 1'b0;
         case (state)
            IDLE, FEED: begin
               in_ready_q <= 1'b1;
               if (accept_c) begin
                  busy <= 1'b1;
                  if (in_if.in_last) begin
                     state      <= FLUSH;
                     in_ready_q <= 1'b0;
                     flush_cnt  <= '0;
                  end else begin
                     state <= FEED;
                  end
               end
            end
            FLUSH: begin
               if (flush_cnt == CW'(FLUSH_LAST)) begin
                  state      <= IDLE;
                  flush_cnt  <= '0;
                  in_ready_q <= 1'b1;
                  busy       <= 1'b0;
                  done       <= 1'b1;
               end else begin
                  flush_cnt <= flush_cnt + CW'(1);
               end
            end
            default: begin
               state      <= IDLE;
               flush_cnt  <= '0;
               in_ready_q <= 1'b1;
               busy       <= 1'b0;
            end
         endcase
      end
   end

   // Per-lane delay chains: lane g has g+1 stages, output is the last stage.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [DW-1:0] d_sr [g+1];
      logic [DW-1:0] w_sr [g+1];
      logic [DW-1:0] d_in_c;
      logic [DW-1:0] w_in_c;

      // Zeros are pushed while draining.
      assign d_in_c = flush_c ? '0 : in_if.in_data[g*DW +: DW];
      assign w_in_c = flush_c ? '0 : in_if.in_weight[g*DW +: DW];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k <= g; k++) begin
               d_sr[k] <= '0;
               w_sr[k] <= '0;
            end
         end else if (clr) begin
            for (int k = 0; k <= g; k++) begin
               d_sr[k] <= '0;
               w_sr[k] <= '0;
            end
         end else if (adv_c) begin
            d_sr[0] <= d_in_c;
            w_sr[0] <= w_in_c;
            for (int k = 1; k <= g; k++) begin
               d_sr[k] <= d_sr[k-1];
               w_sr[k] <= w_sr[k-1];
            end
         end
      end

      assign SA_data_out[g*DW +: DW]   = d_sr[g];
      assign SA_weight_out[g*DW +: DW] = w_sr[g];
   end

endmodule

// File: tb/tb_sa_in_skew.sv
module tb_sa_in_skew;

   localparam int unsigned LANES = 16;
   localparam int unsigned DW    = 8;
   localparam int unsigned W     = LANES * DW;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clr;
   logic         SA_fire_out;
   logic [W-1:0] SA_data_out;
   logic [W-1:0] SA_weight_out;
   logic         busy;
   logic         done;

   sa_in_skew_if #(.LANES(LANES), .DW(DW)) ifc ();

   sa_in_skew #(.LANES(LANES), .DW(DW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (clr),
      .in_if        (ifc),
      .SA_fire_out  (SA_fire_out),
      .SA_data_out  (SA_data_out),
      .SA_weight_out(SA_weight_out),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: every vector pushed into the skew (accepted beats and
   // drain zeros) in order; lane i of the output is lane i of the vector
   // pushed i advances before the newest one.
   logic [W-1:0] hist_d [$];
   logic [W-1:0] hist_w [$];
   int  m_flush;
   bit  m_ready, m_busy, m_fire, m_done, m_acc;

   int fire_seen, fire_low, done_seen, rdy_low;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      hist_d.delete();
      hist_w.delete();
      m_flush = 0;
      m_busy  = 0;
      m_fire  = 0;
      m_done  = 0;
   endtask

   task automatic clear_counts();
      fire_seen = 0; fire_low = 0; done_seen = 0; rdy_low = 0;
   endtask

   function automatic logic [W-1:0] expect_vec(input bit wsel);
      logic [W-1:0] e = '0;
      int n = hist_d.size();
      for (int i = 0; i < int'(LANES); i++) begin
         int idx = n - 1 - i;
         if (idx >= 0) e[i*DW +: DW] = wsel ? hist_w[idx][i*DW +: DW] : hist_d[idx][i*DW +: DW];
      end
      return e;
   endfunction

   task automatic check_cycle();
      chk("fire",   W'(SA_fire_out),  W'(m_fire));
      chk("done",   W'(done),         W'(m_done));
      chk("busy",   W'(busy),         W'(m_busy));
      chk("ready",  W'(ifc.in_ready), W'(m_ready));
      chk("data",   SA_data_out,      expect_vec(1'b0));
      chk("weight", SA_weight_out,    expect_vec(1'b1));
      if (SA_fire_out) fire_seen++; else fire_low++;
      if (done) done_seen++;
      if (!ifc.in_ready) rdy_low++;
   endtask

   // One clock: drive inputs (at negedge), predict, clock, sample at negedge.
   task automatic step(input bit v, input bit l, input logic [W-1:0] d,
                       input logic [W-1:0] w, input bit c);
      ifc.in_valid  = v;
      ifc.in_last   = l;
      ifc.in_data   = d;
      ifc.in_weight = w;
      clr           = c;
      m_acc = 0;
      if (c) begin
         model_clear();
         m_ready = 1;
      end else if (m_flush > 0) begin
         hist_d.push_back('0);
         hist_w.push_back('0);
         m_flush--;
         m_fire  = 1;
         m_done  = (m_flush == 0);
         m_ready = (m_flush == 0);
         m_busy  = (m_flush != 0);
      end else if (v && m_ready) begin
         m_acc = 1;
         hist_d.push_back(d);
         hist_w.push_back(w);
         m_fire = 1;
         m_done = 0;
         m_busy = 1;
         if (l) begin
            m_flush = LANES - 1;
            m_ready = 0;
         end else begin
            m_ready = 1;
         end
      end else begin
         m_fire  = 0;
         m_done  = 0;
         m_ready = 1;
      end
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      check_cycle();
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   // Reset is applied mid-cycle; outputs must clear without a clock edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_fire",  W'(SA_fire_out),  '0);
      chk("rst_done",  W'(done),         '0);
      chk("rst_busy",  W'(busy),         '0);
      chk("rst_ready", W'(ifc.in_ready), '0);
      chk("rst_data",  SA_data_out,      '0);
      chk("rst_wt",    SA_weight_out,    '0);
      model_clear();
      m_ready = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [W-1:0] rnd_vec();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [W-1:0] pat, e, v, b0;
      rst_n = 1'b0;
      clr   = 1'b0;
      ifc.in_valid = 1'b0; ifc.in_last = 1'b0;
      ifc.in_data  = '0;   ifc.in_weight = '0;
      model_clear();
      m_ready = 0;
      @(negedge clk);
      do_reset();
      idle_step();
      chk("ready_after_reset", W'(ifc.in_ready), W'(1));

      // Single beat, lane i = i+1.
      pat = '0;
      for (int i = 0; i < int'(LANES); i++) pat[i*DW +: DW] = DW'(i + 1);
      clear_counts();
      for (int k = 0; k < int'(LANES); k++) begin
         if (k == 0) step(1'b1, 1'b1, pat, pat, 1'b0);
         else        idle_step();
         e = '0;
         e[k*DW +: DW] = DW'(k + 1);
         chk("single_lane", SA_data_out, e);
      end
      chk("single_fires", W'(fire_seen), W'(16));
      chk("single_done",  W'(done_seen), W'(1));
      idle_step();
      idle_step();

      // 16-beat matrix, beat b lanes = FF-b.
      clear_counts();
      for (int b = 0; b < 16; b++) begin
         v = {LANES{DW'(8'hFF - b)}};
         step(1'b1, b == 15, v, v, 1'b0);
         if (b == 0) chk("first_out", SA_data_out, W'(128'hFF));
      end
      for (int k = 0; k < 15; k++) idle_step();
      chk("mat16_fires", W'(fire_seen), W'(31));
      chk("mat16_done",  W'(done_seen), W'(1));
      idle_step();

      // 4-beat matrix, 3-cycle stall after beat 1.
      clear_counts();
      for (int b = 0; b < 4; b++) begin
         v = rnd_vec();
         step(1'b1, b == 3, v, rnd_vec(), 1'b0);
         if (b == 1) for (int s = 0; s < 3; s++) step(1'b0, 1'b0, rnd_vec(), rnd_vec(), 1'b0);
      end
      for (int k = 0; k < 15; k++) idle_step();
      chk("stall_fires", W'(fire_seen), W'(19));
      chk("stall_low",   W'(fire_low),  W'(3));
      idle_step();

      // Back-to-back: second matrix waits with in_valid high during FLUSH.
      for (int b = 0; b < 3; b++) step(1'b1, b == 2, rnd_vec(), rnd_vec(), 1'b0);
      clear_counts();
      rdy_low = 1;
      b0 = rnd_vec();
      begin
         bit got = 0;
         for (int t = 0; t < 30 && !got; t++) begin
            step(1'b1, 1'b0, b0, b0, 1'b0);
            got = m_acc;
         end
         chk("b2b_accepted", W'(got), W'(1));
      end
      chk("b2b_ready_low", W'(rdy_low), W'(15));
      for (int b = 1; b < 4; b++) step(1'b1, b == 3, rnd_vec(), rnd_vec(), 1'b0);
      for (int k = 0; k < 15; k++) idle_step();
      idle_step();

      // Reset at flush cycle 7.
      for (int b = 0; b < 16; b++) step(1'b1, b == 15, rnd_vec(), rnd_vec(), 1'b0);
      clear_counts();
      for (int k = 0; k < 7; k++) idle_step();
      do_reset();
      idle_step();
      chk("rst_mid_ready", W'(ifc.in_ready), W'(1));
      for (int k = 0; k < 10; k++) idle_step();
      chk("rst_mid_nodone", W'(done_seen), W'(0));

      // clr at flush cycle 7.
      for (int b = 0; b < 16; b++) step(1'b1, b == 15, rnd_vec(), rnd_vec(), 1'b0);
      clear_counts();
      for (int k = 0; k < 7; k++) idle_step();
      step(1'b0, 1'b0, '0, '0, 1'b1);
      chk("clr_data", SA_data_out, '0);
      idle_step();
      chk("clr_ready", W'(ifc.in_ready), W'(1));
      for (int k = 0; k < 10; k++) idle_step();
      chk("clr_nodone", W'(done_seen), W'(0));

      // Random matrices with random gaps, valid held through FLUSH at random.
      for (int m = 0; m < 6; m++) begin
         int len = $urandom_range(1, 8);
         int b = 0;
         while (b < len) begin
            bit vv = ($urandom_range(0, 3) != 0);
            step(vv, b == len - 1, rnd_vec(), rnd_vec(), 1'b0);
            if (m_acc) b++;
         end
         while (!m_ready) step($urandom_range(0, 1) == 1, 1'b0, rnd_vec(), rnd_vec(), 1'b0);
      end
      for (int k = 0; k < 20; k++) idle_step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time bound against a hung run.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
